// File: rtl/inv_table_ctrl.sv
// inv_table_ctrl: arbitrates the single port of the 1024x36 reciprocal table RAM between two
//   round-robin read requesters, and runs full-table reloads from a streaming source.
// Latency: request grant is combinational. Read data returns 1 cycle after the grant.
// Backpressure: reqX_ready is low when the other side wins or while loading. ld_ready is high only in LOAD.
//   Responses cannot be stalled.
//
// Ports: clk/rst (sync, active-high); req0_*/req1_* read request + rsp0_*/rsp1_* response per requester;
//   ld_start/ld_valid/ld_data/ld_ready/ld_busy/ld_done reload stream; ram_we/ram_addr/ram_din/ram_dout table port.
// Optional: define INV_TABLE_CTRL_STATS_EN to add stat_grant0/stat_grant1/stat_stall saturating counters.
module inv_table_ctrl #(
    parameter int AW = 10,
    parameter int DW = 36
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    output logic          req0_ready,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_data,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    output logic          req1_ready,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_data,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          ld_busy,
    output logic          ld_done,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
`ifdef INV_TABLE_CTRL_STATS_EN
    ,
    output logic [15:0]   stat_grant0,
    output logic [15:0]   stat_grant1,
    output logic [15:0]   stat_stall
`endif
);

    typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

    state_t        state, state_nxt;
    logic          rr, rr_nxt;          // 0: req0 wins a tie, 1: req1 wins a tie
    logic [AW-1:0] cnt, cnt_nxt;        // next table index to write during LOAD
    logic [AW-1:0] addr_q;              // last driven RAM address, held when idle
    logic          grant0, grant1;
    logic          last_word;

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        cnt_nxt   = cnt;
        grant0    = 1'b0;
        grant1    = 1'b0;
        last_word = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ld_ready  = 1'b0;
        ld_busy   = 1'b0;
        case (state)
            RUN: begin
                if (req0_valid && (!req1_valid || !rr)) begin
                    grant0 = 1'b1;
                end else if (req1_valid) begin
                    grant1 = 1'b1;
                end
                if (grant0) begin
                    ram_addr = req0_addr;
                    rr_nxt   = 1'b1;
                end
                if (grant1) begin
                    ram_addr = req1_addr;
                    rr_nxt   = 1'b0;
                end
                // A grant in this cycle still completes: its data is read
                // before the first LOAD write can touch the table.
                if (ld_start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                ld_ready = 1'b1;
                ld_busy  = 1'b1;
                if (ld_valid) begin
                    ram_we   = 1'b1;
                    ram_addr = cnt;
                    cnt_nxt  = cnt + 1'b1;     // wraps to 0 after the last word
                    if (cnt == '1) begin
                        last_word = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign ram_din    = ld_data;
    assign rsp0_data  = ram_dout;
    assign rsp1_data  = ram_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            rr         <= 1'b0;
            cnt        <= '0;
            addr_q     <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            ld_done    <= 1'b0;
        end else begin
            state      <= state_nxt;
            rr         <= rr_nxt;
            cnt        <= cnt_nxt;
            addr_q     <= ram_addr;
            rsp0_valid <= grant0;
            rsp1_valid <= grant1;
            ld_done    <= last_word;
        end
    end

`ifdef INV_TABLE_CTRL_STATS_EN
    logic stall_cyc;
    assign stall_cyc = (req0_valid && !grant0) || (req1_valid && !grant1);

    always_ff @(posedge clk) begin
        if (rst || ld_start) begin
            stat_grant0 <= '0;
            stat_grant1 <= '0;
            stat_stall  <= '0;
        end else begin
            if (grant0 && stat_grant0 != 16'hFFFF) stat_grant0 <= stat_grant0 + 16'd1;
            if (grant1 && stat_grant1 != 16'hFFFF) stat_grant1 <= stat_grant1 + 16'd1;
            if (stall_cyc && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule
